// File: rtl/reg4_access_arbiter.sv
// Round-robin arbiter sharing one small D-register (load/set/clear strobes) among NREQ
// requesters; the winner's op is held on the strobes for HOLD_CYC cycles, then done pulses.
module reg4_access_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic                     C,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [DATA_W*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [DATA_W-1:0]        reg_D,
  output logic                     reg_ld,
  output logic                     reg_set,
  output logic                     reg_clr
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SumW = PtrW + 1;
  localparam int unsigned CntW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpSet  = 2'b01;
  localparam logic [1:0] OpClr  = 2'b10;

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     ptr_q;
  logic [PtrW-1:0]     win_q;
  logic [CntW-1:0]     cnt_q;
  logic [NREQ-1:0]     gnt_q;
  logic [NREQ-1:0]     done_q;
  logic                busy_q;
  logic [DATA_W-1:0]   reg_d_q;
  logic                ld_q;
  logic                set_q;
  logic                clr_q;

  logic [1:0]          op_arr   [NREQ];
  logic [DATA_W-1:0]   data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g]   = op[2*g +: 2];
    assign data_arr[g] = wdata[DATA_W*g +: DATA_W];
  end

  // Search starts at ptr_q and wraps, so the most recent winner has lowest priority.
  logic            any_req;
  logic [PtrW-1:0] arb_idx;
  logic [SumW-1:0] sum;

  always_comb begin
    any_req = 1'b0;
    arb_idx = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + SumW'(k);
      if (sum >= SumW'(NREQ)) begin
        sum = sum - SumW'(NREQ);
      end
      if (!any_req && req[sum[PtrW-1:0]]) begin
        any_req = 1'b1;
        arb_idx = sum[PtrW-1:0];
      end
    end
  end

  logic [1:0] sel_op;
  assign sel_op = op_arr[arb_idx];

  always_ff @(posedge C) begin
    if (clr) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      reg_d_q <= '0;
      ld_q    <= 1'b0;
      set_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StDrive;
            win_q   <= arb_idx;
            cnt_q   <= '0;
            gnt_q   <= NREQ'(1) << arb_idx;
            busy_q  <= 1'b1;
            reg_d_q <= data_arr[arb_idx];
            ld_q    <= (sel_op == OpLoad);
            set_q   <= (sel_op == OpSet);
            clr_q   <= (sel_op == OpClr);
          end
        end
        StDrive: begin
          if (cnt_q == CntW'(HOLD_CYC - 1)) begin
            state_q <= StDone;
            done_q  <= gnt_q;
            reg_d_q <= '0;
            ld_q    <= 1'b0;
            set_q   <= 1'b0;
            clr_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign reg_D   = reg_d_q;
  assign reg_ld  = ld_q;
  assign reg_set = set_q;
  assign reg_clr = clr_q;

endmodule

// File: tb/tb_reg4_access_arbiter.sv
// Bench for reg4_access_arbiter: two instances (HOLD_CYC 1 and 3) share stimulus; a timeline
// model predicts every output each cycle, and literal pins fix key cycles by hand.
module tb_reg4_access_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 4;
  localparam int NINST  = 2;

  localparam int F_GNT  = 0;
  localparam int F_DONE = 1;
  localparam int F_BUSY = 2;
  localparam int F_LD   = 3;
  localparam int F_SET  = 4;
  localparam int F_CLR  = 5;
  localparam int F_REGD = 6;

  logic                   C = 1'b0;
  logic                   clr;
  logic [NREQ-1:0]        req;
  logic [2*NREQ-1:0]      op;
  logic [DATA_W*NREQ-1:0] wdata;

  logic [NREQ-1:0]   gnt_w  [NINST];
  logic [NREQ-1:0]   done_w [NINST];
  logic              busy_w [NINST];
  logic [DATA_W-1:0] regd_w [NINST];
  logic              ld_w   [NINST];
  logic              set_w  [NINST];
  logic              clrs_w [NINST];

  always #5 C = ~C;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    reg4_access_arbiter #(
      .NREQ    (NREQ),
      .DATA_W  (DATA_W),
      .HOLD_CYC((g == 0) ? 1 : 3)
    ) u_dut (
      .C      (C),
      .clr    (clr),
      .req    (req),
      .op     (op),
      .wdata  (wdata),
      .gnt    (gnt_w[g]),
      .done   (done_w[g]),
      .busy   (busy_w[g]),
      .reg_D  (regd_w[g]),
      .reg_ld (ld_w[g]),
      .reg_set(set_w[g]),
      .reg_clr(clrs_w[g])
    );
  end

  function automatic int hold_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Model: an op occupies ages 1..H (strobes) and H+1 (done) after its grant edge.
  int  cyc = 0;
  bit  mvalid = 1'b0;
  bit  active [NINST];
  int  age    [NINST];
  int  win    [NINST];
  int  mop    [NINST];
  int  mdata  [NINST];
  int  ptr    [NINST];
  int  mj;
  bit  mfound;

  initial begin
    for (int i = 0; i < NINST; i++) begin
      active[i] = 1'b0; age[i] = 0; win[i] = 0; mop[i] = 3; mdata[i] = 0; ptr[i] = 0;
    end
    forever begin
      @(posedge C);
      cyc++;
      for (int i = 0; i < NINST; i++) begin
        if (clr) begin
          active[i] = 1'b0;
          ptr[i]    = 0;
          mvalid    = 1'b1;
        end else if (active[i]) begin
          if (age[i] == hold_of(i) + 1) begin
            active[i] = 1'b0;
            ptr[i]    = (win[i] + 1) % NREQ;
          end else begin
            age[i]++;
          end
        end else if (req != '0) begin
          mfound = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            mj = (ptr[i] + k) % NREQ;
            if (!mfound && req[mj]) begin
              mfound = 1'b1;
              win[i] = mj;
            end
          end
          active[i] = 1'b1;
          age[i]    = 1;
          mop[i]    = int'(op[2*win[i] +: 2]);
          mdata[i]  = int'(wdata[DATA_W*win[i] +: DATA_W]);
        end
      end
    end
  end

  typedef struct {
    int    cyc;
    int    inst;
    int    fld;
    int    val;
    string nm;
  } pin_t;

  pin_t pins[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] act_of(int inst, int fld);
    case (fld)
      F_GNT:   return 32'(gnt_w[inst]);
      F_DONE:  return 32'(done_w[inst]);
      F_BUSY:  return 32'(busy_w[inst]);
      F_LD:    return 32'(ld_w[inst]);
      F_SET:   return 32'(set_w[inst]);
      F_CLR:   return 32'(clrs_w[inst]);
      default: return 32'(regd_w[inst]);
    endcase
  endfunction

  task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
    end
  endtask

  // Single compare process: model check on every cycle after reset, plus literal pins.
  logic [31:0] e_gnt, e_done;
  bit          e_drive;
  initial begin
    forever begin
      @(negedge C);
      if (mvalid) begin
        for (int i = 0; i < NINST; i++) begin
          e_gnt   = active[i] ? (32'd1 << win[i]) : 32'd0;
          e_done  = (active[i] && age[i] == hold_of(i) + 1) ? e_gnt : 32'd0;
          e_drive = active[i] && (age[i] <= hold_of(i));
          chk("gnt",  i, act_of(i, F_GNT),  e_gnt);
          chk("done", i, act_of(i, F_DONE), e_done);
          chk("busy", i, act_of(i, F_BUSY), 32'(active[i]));
          chk("ld",   i, act_of(i, F_LD),   32'(e_drive && mop[i] == 0));
          chk("set",  i, act_of(i, F_SET),  32'(e_drive && mop[i] == 1));
          chk("clr",  i, act_of(i, F_CLR),  32'(e_drive && mop[i] == 2));
          if (e_drive) chk("reg_D", i, act_of(i, F_REGD), 32'(mdata[i]));
        end
      end
      foreach (pins[k]) begin
        if (pins[k].cyc == cyc) chk(pins[k].nm, pins[k].inst, act_of(pins[k].inst, pins[k].fld),
                                    32'(pins[k].val));
      end
    end
  end

  task automatic tick();
    @(posedge C);
    #2;
  endtask

  task automatic pin(int dc, int inst, int fld, int val, string nm);
    pin_t p;
    p.cyc = cyc + dc; p.inst = inst; p.fld = fld; p.val = val; p.nm = nm;
    pins.push_back(p);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; req = '0; op = '1; wdata = '0;
    tick();
    tick();
    for (int i = 0; i < NINST; i++) begin
      for (int f = F_GNT; f <= F_REGD; f++) pin(0, i, f, 0, "reset_out");
    end

    // 1: single load
    clr = 1'b0; req = 4'b0001; op = 8'hFC; wdata = 16'h000A;
    pin(1, 0, F_GNT, 1, "t1_gnt");   pin(1, 0, F_LD, 1, "t1_ld");
    pin(1, 0, F_REGD, 'hA, "t1_regd"); pin(1, 0, F_BUSY, 1, "t1_busy");
    pin(2, 0, F_DONE, 1, "t1_done"); pin(2, 0, F_LD, 0, "t1_ld_off");
    pin(3, 0, F_BUSY, 0, "t1_idle");
    tick(); tick(); req = '0;
    repeat (6) tick();

    // 2: all requesting, round-robin order 0,1,2,3,0
    do_reset();
    req = 4'b1111; op = 8'h00; wdata = 16'h4321;
    pin(1, 0, F_GNT, 1, "t2_g0");  pin(4, 0, F_GNT, 2, "t2_g1");
    pin(7, 0, F_GNT, 4, "t2_g2");  pin(10, 0, F_GNT, 8, "t2_g3");
    pin(13, 0, F_GNT, 1, "t2_g0b");
    pin(2, 0, F_DONE, 1, "t2_d0"); pin(5, 0, F_DONE, 2, "t2_d1");
    pin(8, 0, F_DONE, 4, "t2_d2"); pin(11, 0, F_DONE, 8, "t2_d3");
    pin(4, 0, F_REGD, 2, "t2_regd1"); pin(3, 0, F_BUSY, 0, "t2_gap");
    repeat (13) tick();
    req = '0;
    repeat (8) tick();

    // 3: set then clear
    do_reset();
    req = 4'b0110; op = 8'b11_10_01_11; wdata = 16'h0960;
    pin(1, 0, F_GNT, 2, "t3_gset"); pin(1, 0, F_SET, 1, "t3_set");
    pin(1, 0, F_LD, 0, "t3_noload"); pin(1, 0, F_CLR, 0, "t3_noclr1");
    pin(2, 0, F_DONE, 2, "t3_d1");
    pin(4, 0, F_GNT, 4, "t3_gclr"); pin(4, 0, F_CLR, 1, "t3_clr");
    pin(4, 0, F_SET, 0, "t3_noset"); pin(5, 0, F_DONE, 4, "t3_d2");
    repeat (5) tick();
    req = '0;
    repeat (8) tick();

    // 4: HOLD_CYC=3 instance, req dropped mid-op
    do_reset();
    req = 4'b0001; op = 8'hFC; wdata = 16'h0005;
    pin(1, 1, F_GNT, 1, "t4_gnt"); pin(1, 1, F_LD, 1, "t4_ld1");
    pin(2, 1, F_LD, 1, "t4_ld2");  pin(3, 1, F_LD, 1, "t4_ld3");
    pin(3, 1, F_REGD, 5, "t4_regd"); pin(4, 1, F_LD, 0, "t4_ld_off");
    pin(4, 1, F_DONE, 1, "t4_done"); pin(5, 1, F_BUSY, 0, "t4_idle");
    tick(); req = '0;
    repeat (7) tick();

    // 5: abort in DRIVE, pointer returns to 0
    do_reset();
    req = 4'b0100; op = 8'h00; wdata = 16'h1234;
    tick(); req = '0;
    repeat (6) tick();
    req = 4'b1001;
    pin(1, 0, F_GNT, 8, "t5_g3"); pin(1, 1, F_GNT, 8, "t5_g3_h3");
    tick(); clr = 1'b1;
    pin(1, 0, F_GNT, 0, "t5_ab_gnt"); pin(1, 0, F_DONE, 0, "t5_ab_done");
    pin(1, 0, F_BUSY, 0, "t5_ab_busy"); pin(1, 0, F_LD, 0, "t5_ab_ld");
    pin(1, 1, F_GNT, 0, "t5_ab_gnt_h3"); pin(1, 1, F_BUSY, 0, "t5_ab_busy_h3");
    tick(); clr = 1'b0;
    pin(1, 0, F_GNT, 1, "t5_restart"); pin(1, 1, F_GNT, 1, "t5_restart_h3");
    tick(); req = '0;
    repeat (7) tick();

    // 6: no-op advances pointer; clr dominates a simultaneous req
    clr = 1'b1; req = 4'b0011; op = 8'hF3; wdata = 16'h00B7;
    pin(1, 0, F_BUSY, 0, "t6_clr_dom"); pin(1, 0, F_GNT, 0, "t6_clr_gnt");
    tick(); clr = 1'b0;
    pin(1, 0, F_GNT, 1, "t6_gnop"); pin(1, 0, F_BUSY, 1, "t6_busy");
    pin(1, 0, F_LD, 0, "t6_nold"); pin(1, 0, F_SET, 0, "t6_noset");
    pin(1, 0, F_CLR, 0, "t6_noclr"); pin(2, 0, F_DONE, 1, "t6_done");
    pin(4, 0, F_GNT, 2, "t6_next"); pin(4, 0, F_LD, 1, "t6_ld");
    pin(4, 0, F_REGD, 'hB, "t6_regd");
    repeat (4) tick();
    req = '0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
